// File: rtl/disp_src_sel_io.sv
// ----------------------------------------------------------------------------
// disp_src_sel_io
//
// Display-source selector for the seven-segment path. Holds a CPU-writable
// display register (channel 0, byte-enable writes) and registers one of NCH
// channels onto disp_num. Channel PC_CH is shown right-shifted by PC_SHIFT
// (byte PC -> word PC). A freeze input holds the display and the scan state
// while still letting the CPU register take writes.
//
// Optional feature (compile-time macro DISP_AUTO_SCAN_EN):
//   defined   : auto-scan rotates cur_ch through all channels, dwelling
//               2**SCAN_DIV clock cycles per channel, pulsing scan_tick on
//               each advance.
//   undefined : manual only; auto_mode is ignored, scan_tick is tied to 0.
//
// All registers update on the FALLING edge of clk; reset is asynchronous,
// active-high.
//
// Ports:
//   clk          in   1        clock (falling-edge active)
//   reset        in   1        asynchronous active-high reset
//   cpu_we       in   1        CPU write strobe
//   cpu_be       in   DW/8     byte enables for cpu_data (bit i -> byte i)
//   cpu_data     in   DW       CPU write data
//   test_select  in   SELW     manual channel select
//   auto_mode    in   1        1 = auto-scan, 0 = manual
//   freeze       in   1        1 = hold disp_num, cur_ch and scan state
//   test_bus     in   NCH*DW   channel k on [k*DW +: DW]; slice 0 unused
//   disp_num     out  DW       registered display value
//   cur_ch       out  SELW     channel currently shown (registered)
//   scan_tick    out  1        one-cycle pulse when auto-scan advances
// ----------------------------------------------------------------------------
module disp_src_sel_io #(
    parameter int          DW       = 32,
    parameter int          NCH      = 8,
    parameter int          SELW     = 3,
    parameter int          PC_CH    = 1,
    parameter int          PC_SHIFT = 2,
    parameter logic [31:0] RST_VAL  = 32'h12345678,
    parameter int          SCAN_DIV = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_we,
    input  logic [DW/8-1:0]     cpu_be,
    input  logic [DW-1:0]       cpu_data,
    input  logic [SELW-1:0]     test_select,
    input  logic                auto_mode,
    input  logic                freeze,
    input  logic [NCH*DW-1:0]   test_bus,
    output logic [DW-1:0]       disp_num,
    output logic [SELW-1:0]     cur_ch,
    output logic                scan_tick
);

    localparam int NB = DW / 8;

    logic [DW-1:0]   cpu_reg;
    logic [DW-1:0]   cpu_reg_next;
    logic [DW-1:0]   man_val;
    logic [DW-1:0]   cur_val;
    logic [SELW-1:0] cur_ch_adv;
    logic            sel_ok;
    logic            mode_auto;
    logic            scan_wrap;

    // Slice 0 of test_bus is replaced by the CPU register.
    logic unused_bus0;
    assign unused_bus0 = ^test_bus[DW-1:0];

    // Channel value. Channel 0 is the post-write CPU register, so a write is
    // visible on disp_num at the same edge it lands.
    function automatic logic [DW-1:0] ch_val(input logic [SELW-1:0]   k,
                                             input logic [DW-1:0]     reg_next,
                                             input logic [NCH*DW-1:0] bus);
        ch_val = reg_next;
        for (int c = 1; c < NCH; c++) begin
            if (int'(k) == c) begin
                if (c == PC_CH) ch_val = bus[c*DW +: DW] >> PC_SHIFT;
                else            ch_val = bus[c*DW +: DW];
            end
        end
    endfunction

    always_comb begin
        cpu_reg_next = cpu_reg;
        for (int i = 0; i < NB; i++) begin
            if (cpu_we && cpu_be[i]) cpu_reg_next[i*8 +: 8] = cpu_data[i*8 +: 8];
        end
    end

    assign man_val    = ch_val(test_select, cpu_reg_next, test_bus);
    assign cur_val    = ch_val(cur_ch, cpu_reg_next, test_bus);
    assign sel_ok     = int'(test_select) < NCH;
    assign cur_ch_adv = (cur_ch == SELW'(NCH - 1)) ? '0 : cur_ch + 1'b1;

`ifdef DISP_AUTO_SCAN_EN
    logic [SCAN_DIV-1:0] scan_cnt;

    assign mode_auto = auto_mode;
    assign scan_wrap = (scan_cnt == '1);

    // Dwell counter. Held at 0 in manual mode so entering auto mode always
    // starts a full dwell on the current channel. Wraps naturally at all-ones.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end else if (freeze) begin
            scan_tick <= 1'b0;
        end else if (mode_auto) begin
            scan_cnt  <= scan_cnt + 1'b1;
            scan_tick <= scan_wrap;
        end else begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end
    end
`else
    logic                unused_auto;
    logic [SCAN_DIV-1:0] unused_scan_w;

    assign mode_auto     = 1'b0;
    assign scan_wrap     = 1'b0;
    assign scan_tick     = 1'b0;
    assign unused_scan_w = '0;
    assign unused_auto   = auto_mode;
`endif

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cpu_reg  <= RST_VAL[DW-1:0];
            disp_num <= RST_VAL[DW-1:0];
            cur_ch   <= '0;
        end else begin
            // CPU writes are accepted regardless of freeze or selection.
            cpu_reg <= cpu_reg_next;
            if (freeze) begin
                disp_num <= disp_num;
                cur_ch   <= cur_ch;
            end else if (mode_auto) begin
                // Display follows the channel already shown, so it trails a
                // channel advance by one edge and stays live meanwhile.
                disp_num <= cur_val;
                if (scan_wrap) cur_ch <= cur_ch_adv;
            end else if (sel_ok) begin
                cur_ch   <= test_select;
                disp_num <= man_val;
            end
        end
    end

endmodule
